midi_tx: RTL and testbench

MIDI_TX -- requirements
Module: midi_tx

---
 rtl/midi_pkg.sv | 14 +
 rtl/midi_tx_baud_tick.sv | 29 ++
 rtl/midi_tx.sv | 118 +++++++++++
 tb/tb_midi_tx.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI serial transmitter: FSM encoding and frame shape.
package midi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 10;

endpackage

// File: rtl/midi_tx_baud_tick.sv
// Bit-period timer: counts 0..DIV-1 and pulses tick on the last count of each period.
module baud_tick #(
    parameter int unsigned DIV = 3200,
    parameter int unsigned CW  = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Modulo-DIV counter; restart pins it at zero so a period starts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (restart || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST) & ~restart;

endmodule

// File: rtl/midi_tx.sv
// MIDI (8N1) serial transmitter with a one-byte holding register for gapless streaming.
module midi_tx
    import midi_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned BAUD   = 31250,
    parameter int unsigned CW     = 12
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] D,
    input  logic       WR,
    output logic       RDY,
    output logic       TX,
    output logic       BUSY
);

    localparam int unsigned DIV      = CLK_HZ / BAUD;
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    state_e     state;
    logic [7:0] hold;
    logic       hold_full;
    logic [7:0] shifter;
    logic [2:0] bit_idx;
    logic       tx_reg;

    logic tick;
    logic restart;
    logic accept;
    logic load;

    // The timer idles at zero so the start bit gets a full period from the load edge.
    assign restart = (state == IDLE);
    assign accept  = WR & ~hold_full;
    // Shifter loads from hold either straight out of IDLE or at the end of a stop bit.
    assign load    = hold_full & ((state == IDLE) | ((state == STOP) & tick));

    baud_tick #(
        .DIV (DIV),
        .CW  (CW)
    ) u_baud_tick (
        .clk     (CLK),
        .rst_n   (RST_N),
        .restart (restart),
        .tick    (tick)
    );

    // Holding register: filled by an accepted write, emptied when the FSM loads the shifter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (load) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= D;
            hold_full <= 1'b1;
        end
    end

    // Frame sequencer: start bit, eight data bits LSB first, stop bit; TX is registered.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            shifter <= '0;
            bit_idx <= '0;
            tx_reg  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hold_full) begin
                        state   <= START;
                        shifter <= hold;
                        tx_reg  <= 1'b0;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        tx_reg  <= shifter[0];
                        shifter <= {1'b0, shifter[7:1]};
                    end
                end
                DATA: begin
                    if (tick) begin
                        // Index wraps 7 -> 0 on the way out, ready for the next frame.
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) begin
                            state  <= STOP;
                            tx_reg <= 1'b1;
                        end else begin
                            tx_reg  <= shifter[0];
                            shifter <= {1'b0, shifter[7:1]};
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (hold_full) begin
                            state   <= START;
                            shifter <= hold;
                            tx_reg  <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign TX   = tx_reg;
    assign RDY  = ~hold_full;
    assign BUSY = (state != IDLE) | hold_full;

endmodule

// File: tb/tb_midi_tx.sv
// Scoreboard bench for midi_tx at DIV=10: stimulus queues expected bytes, a line monitor
// decodes every frame cycle by cycle and compares against the queue.
module tb_midi_tx;
    import midi_pkg::*;

    localparam int unsigned DIV   = 10;
    localparam int unsigned FRAME = FRAME_BITS * DIV;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic       WR    = 1'b0;
    logic [7:0] D     = 8'h00;
    logic       RDY;
    logic       TX;
    logic       BUSY;

    typedef struct packed {
        logic [7:0] d;
        logic       b2b;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    midi_tx #(
        .CLK_HZ (1000),
        .BAUD   (100),
        .CW     (4)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .D    (D),
        .WR   (WR),
        .RDY  (RDY),
        .TX   (TX),
        .BUSY (BUSY)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic expect_byte(input logic [7:0] d, input logic b2b);
        exp_t e;
        e.d   = d;
        e.b2b = b2b;
        exp_q.push_back(e);
    endtask

    // Expected line level at cycle j of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int j);
        int b;
        b = j / DIV;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return d[b-1];
    endfunction

    function automatic int exp_low(input logic [7:0] d);
        int z;
        z = 1;
        for (int i = 0; i < 8; i++) if (!d[i]) z++;
        return z * DIV;
    endfunction

    // Line monitor: each falling edge of TX starts a frame that must match the queue head.
    initial begin : monitor
        int   gap;
        int   bad;
        int   low;
        bit   aborted;
        exp_t e;
        gap = 1000;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                gap = 1000;
            end else if (TX) begin
                gap++;
            end else if (exp_q.size() == 0) begin
                check("frame_unexpected", 1, 0);
                repeat (FRAME - 1) @(negedge CLK);
                gap = 0;
            end else begin
                e = exp_q.pop_front();
                if (e.b2b) check($sformatf("frame_gap %02h", e.d), gap, 0);
                bad     = 0;
                low     = 0;
                aborted = 0;
                for (int j = 0; j < FRAME; j++) begin
                    if (j > 0) @(negedge CLK);
                    if (!RST_N) begin
                        aborted = 1;
                        break;
                    end
                    if (!TX) low++;
                    if (TX !== exp_bit(e.d, j)) bad++;
                end
                if (!aborted) begin
                    check($sformatf("frame_wave %02h", e.d), bad, 0);
                    check($sformatf("frame_low %02h", e.d), low, exp_low(e.d));
                    gap = 0;
                end else begin
                    gap = 1000;
                end
            end
        end
    end

    task automatic wait_idle(input string name, output int n);
        n = 0;
        while (BUSY && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (BUSY) check({name, "_timeout"}, 1, 0);
    endtask

    task automatic wait_rdy(input string name, output int n);
        n = 0;
        while (!RDY && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (!RDY) check({name, "_timeout"}, 1, 0);
    endtask

    // Directed stimulus; each write is issued at a falling edge and taken on the next rise.
    initial begin : stim
        int n;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_tx", TX, 1);
        check("rst_rdy", RDY, 1);
        check("rst_busy", BUSY, 0);

        // Single byte, written on the very first edge after reset release.
        #2;
        RST_N = 1'b1;
        expect_byte(8'hA5, 1'b0);
        D  = 8'hA5;
        WR = 1'b1;
        @(negedge CLK);
        WR = 1'b0;
        check("a5_rdy_held", RDY, 0);
        check("a5_busy", BUSY, 1);
        check("a5_tx_before", TX, 1);
        @(negedge CLK);
        check("a5_tx_latency", TX, 0);
        wait_idle("a5", n);
        check("a5_busy_after_start", n, FRAME);

        // Back-to-back: second byte written as soon as RDY returns.
        @(negedge CLK);
        expect_byte(8'h90, 1'b0);
        expect_byte(8'h3C, 1'b1);
        D  = 8'h90;
        WR = 1'b1;
        @(negedge CLK);
        WR = 1'b0;
        wait_rdy("b2b_rdy", n);
        check("b2b_rdy_wait", n, 1);
        D  = 8'h3C;
        WR = 1'b1;
        @(negedge CLK);
        WR = 1'b0;
        check("b2b_second_held", RDY, 0);
        wait_idle("b2b", n);
        // Two frames of 200 cycles total, measured from the second start-bit cycle.
        check("b2b_busy_len", n, 2 * FRAME - 1);

        // Three writes on consecutive edges from IDLE: the second lands on the load
        // edge where RDY is 0 and is dropped; the third refills the holding register.
        @(negedge CLK);
        expect_byte(8'h01, 1'b0);
        expect_byte(8'h03, 1'b1);
        D  = 8'h01;
        WR = 1'b1;
        @(negedge CLK);
        check("ovr_rdy_at_second", RDY, 0);
        D = 8'h02;
        @(negedge CLK);
        check("ovr_rdy_at_third", RDY, 1);
        D = 8'h03;
        @(negedge CLK);
        WR = 1'b0;
        check("ovr_third_held", RDY, 0);
        wait_idle("ovr", n);

        // Overrun with the held byte already taken: 02 held, 03 ignored while full.
        @(negedge CLK);
        expect_byte(8'h01, 1'b0);
        expect_byte(8'h02, 1'b1);
        D  = 8'h01;
        WR = 1'b1;
        @(negedge CLK);
        WR = 1'b0;
        wait_rdy("ovr2_rdy", n);
        D  = 8'h02;
        WR = 1'b1;
        @(negedge CLK);
        D = 8'h03;
        check("ovr2_rdy_at_03", RDY, 0);
        @(negedge CLK);
        WR = 1'b0;
        check("ovr2_still_full", RDY, 0);
        wait_idle("ovr2", n);

        // Reset 45 cycles into a frame: line released at once, frame abandoned.
        @(negedge CLK);
        expect_byte(8'h55, 1'b0);
        D  = 8'h55;
        WR = 1'b1;
        @(negedge CLK);
        WR = 1'b0;
        n  = 0;
        while (TX && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("rstmid_start_seen", TX, 0);
        repeat (45) @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("rstmid_tx", TX, 1);
        check("rstmid_rdy", RDY, 1);
        check("rstmid_busy", BUSY, 0);
        @(negedge CLK);
        #2;
        RST_N = 1'b1;
        expect_byte(8'hF0, 1'b0);
        D  = 8'hF0;
        WR = 1'b1;
        @(negedge CLK);
        WR = 1'b0;
        check("rstmid_f0_accepted", RDY, 0);
        wait_idle("f0", n);
        check("f0_busy_len", n, FRAME + 1);

        // Boundary bytes: all-zero and all-one data.
        @(negedge CLK);
        expect_byte(8'h00, 1'b0);
        D  = 8'h00;
        WR = 1'b1;
        @(negedge CLK);
        WR = 1'b0;
        wait_idle("b00", n);
        check("b00_busy_len", n, FRAME + 1);
        @(negedge CLK);
        expect_byte(8'hFF, 1'b0);
        D  = 8'hFF;
        WR = 1'b1;
        @(negedge CLK);
        WR = 1'b0;
        wait_idle("bff", n);
        check("bff_busy_len", n, FRAME + 1);

        repeat (5) @(negedge CLK);
        check("queue_drained", exp_q.size(), 0);
        check("final_tx_idle", TX, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
